// File: rtl/parking_meter_pkg.sv
// Parking meter shared definitions:
// coin amounts, load values, FSM states.
package parking_meter_pkg;

  localparam int unsigned ADD_50   = 50;
  localparam int unsigned ADD_150  = 150;
  localparam int unsigned ADD_200  = 200;
  localparam int unsigned ADD_500  = 500;

  localparam int unsigned LOAD_10  = 10;
  localparam int unsigned LOAD_205 = 205;

  localparam int unsigned LOW_THRESH = 200;

  typedef enum logic [1:0] {
    ST_HIGH    = 2'd0,
    ST_LOW     = 2'd1,
    ST_EXPIRED = 2'd2
  } state_t;

  function automatic state_t state_of(
    input logic [15:0] v
  );
    state_t s;
    if (v == 16'd0) begin
      s = ST_EXPIRED;
    end else if (v >= 16'(LOW_THRESH)) begin
      s = ST_HIGH;
    end else begin
      s = ST_LOW;
    end
    return s;
  endfunction

endpackage

// File: rtl/parking_meter_ctrl_tick.sv
// Prescaler: one-second and half-second
// strobes, restartable from count 0.
module meter_tick_gen #(
  parameter int unsigned CLK_HZ = 100_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic restart,
  output logic sec_tick,
  output logic half_tick
);

  localparam int unsigned CW = $clog2(CLK_HZ);
  localparam logic [CW-1:0] LAST = CW'(CLK_HZ - 1);
  localparam logic [CW-1:0] MID  = CW'(CLK_HZ / 2 - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    if (restart || cnt_q == LAST) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  assign sec_tick  = (cnt_q == LAST);
  assign half_tick = (cnt_q == MID) || sec_tick;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/parking_meter_ctrl.sv
// Parking meter countdown datapath,
// HIGH/LOW/EXPIRED FSM and display blanking.
module parking_meter_ctrl
  import parking_meter_pkg::*;
#(
  parameter int unsigned CLK_HZ   = 100_000_000,
  parameter int unsigned MAX_TIME = 9999
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        add_50,
  input  logic        add_150,
  input  logic        add_200,
  input  logic        add_500,
  input  logic        rst_10,
  input  logic        rst_205,
  output logic [15:0] meter_data,
  output logic        blank,
  output logic        expired,
  output logic [1:0]  state
);

  logic        sec_tick;
  logic        half_tick;
  logic        load;
  logic [15:0] load_val;
  logic [16:0] amt;
  logic [16:0] base;
  logic [16:0] sum;
  logic        dec;

  logic [15:0] meter_q;
  logic [15:0] meter_d;
  state_t      state_q;
  state_t      state_d;
  logic        blank_q;
  logic        blank_d;
  logic        expired_q;
  logic        expired_d;

  meter_tick_gen #(
    .CLK_HZ(CLK_HZ)
  ) u_tick (
    .clk      (clk),
    .reset    (reset),
    .restart  (load),
    .sec_tick (sec_tick),
    .half_tick(half_tick)
  );

  // Only the highest-priority request in a cycle is honoured
  always_comb begin
    load     = 1'b0;
    load_val = '0;
    amt      = '0;
    priority case (1'b1)
      rst_205: begin
        load     = 1'b1;
        load_val = 16'(LOAD_205);
      end
      rst_10: begin
        load     = 1'b1;
        load_val = 16'(LOAD_10);
      end
      add_500: amt = 17'(ADD_500);
      add_200: amt = 17'(ADD_200);
      add_150: amt = 17'(ADD_150);
      add_50:  amt = 17'(ADD_50);
      default: ;
    endcase
  end

  always_comb begin
    dec  = sec_tick && (meter_q != 16'd0);
    base = {1'b0, meter_q} - {16'd0, dec};
    sum  = base + amt;
    if (load) begin
      meter_d = load_val;
    end else if (sum > 17'(MAX_TIME)) begin
      meter_d = 16'(MAX_TIME);
    end else begin
      meter_d = sum[15:0];
    end
  end

  // Flash phase restarts dark-off on any state change or load
  always_comb begin
    state_d   = state_of(meter_d);
    expired_d = (state_d == ST_EXPIRED);
    blank_d   = 1'b0;
    if (!load && state_d == state_q) begin
      unique case (state_d)
        ST_LOW:     blank_d = blank_q ^ sec_tick;
        ST_EXPIRED: blank_d = blank_q ^ half_tick;
        default:    blank_d = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      meter_q   <= '0;
      state_q   <= ST_EXPIRED;
      blank_q   <= 1'b0;
      expired_q <= 1'b1;
    end else begin
      meter_q   <= meter_d;
      state_q   <= state_d;
      blank_q   <= blank_d;
      expired_q <= expired_d;
    end
  end

  assign meter_data = meter_q;
  assign blank      = blank_q;
  assign expired    = expired_q;
  assign state      = state_q;

endmodule

// File: tb/tb_parking_meter_ctrl.sv
// Bench for parking_meter_ctrl: directed
// literal checks plus randomized model compare.
module tb_parking_meter_ctrl;

  localparam int CLK_HZ = 8;
  localparam int MAX_T  = 9999;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic add_50 = 1'b0;
  logic add_150 = 1'b0;
  logic add_200 = 1'b0;
  logic add_500 = 1'b0;
  logic rst_10 = 1'b0;
  logic rst_205 = 1'b0;
  logic [15:0] meter_data;
  logic blank;
  logic expired;
  logic [1:0] state;

  int checks = 0;
  int failures = 0;

  int m_val = 0;
  int m_age = 0;
  bit m_blank = 1'b0;
  bit m_valid = 1'b0;

  parking_meter_ctrl #(
    .CLK_HZ(CLK_HZ),
    .MAX_TIME(MAX_T)
  ) dut (
    .clk(clk),
    .reset(reset),
    .add_50(add_50),
    .add_150(add_150),
    .add_200(add_200),
    .add_500(add_500),
    .rst_10(rst_10),
    .rst_205(rst_205),
    .meter_data(meter_data),
    .blank(blank),
    .expired(expired),
    .state(state)
  );

  always #5 clk = ~clk;

  // 0 = HIGH, 1 = LOW, 2 = EXPIRED
  function automatic int mode_of(int v);
    if (v == 0) return 2;
    if (v >= 200) return 0;
    return 1;
  endfunction

  task automatic chk(string nm, int act, int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s t=%0t got=%0d exp=%0d",
               nm, $time, act, exp);
    end
  endtask

  // Reference model: seconds remaining, cycles since restart
  always @(posedge clk) begin : model
    int nv;
    int amt;
    int om;
    int nm;
    bit sec;
    bit half;
    bit ld;
    if (reset) begin
      m_val   <= 0;
      m_age   <= 0;
      m_blank <= 1'b0;
      m_valid <= 1'b1;
    end else begin
      sec  = (m_age % CLK_HZ) == CLK_HZ - 1;
      half = (m_age % (CLK_HZ / 2)) == CLK_HZ / 2 - 1;
      om   = mode_of(m_val);
      ld   = 1'b0;
      amt  = 0;
      nv   = m_val;
      if (rst_205) begin ld = 1'b1; nv = 205; end
      else if (rst_10) begin ld = 1'b1; nv = 10; end
      else if (add_500) amt = 500;
      else if (add_200) amt = 200;
      else if (add_150) amt = 150;
      else if (add_50) amt = 50;
      if (ld) begin
        m_val   <= nv;
        m_age   <= 0;
        m_blank <= 1'b0;
      end else begin
        if (sec && nv > 0) nv = nv - 1;
        nv = nv + amt;
        if (nv > MAX_T) nv = MAX_T;
        nm = mode_of(nv);
        m_val <= nv;
        m_age <= m_age + 1;
        if (nm != om) m_blank <= 1'b0;
        else if (nm == 1) m_blank <= m_blank ^ sec;
        else if (nm == 2) m_blank <= m_blank ^ half;
        else m_blank <= 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      chk("meter", int'(meter_data), m_val);
      chk("state", int'(state), mode_of(m_val));
      chk("expired", int'(expired), int'(m_val == 0));
      chk("blank", int'(blank), int'(m_blank));
    end
  end

  task automatic cyc(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clr();
    add_50 = 1'b0;
    add_150 = 1'b0;
    add_200 = 1'b0;
    add_500 = 1'b0;
    rst_10 = 1'b0;
    rst_205 = 1'b0;
  endtask

  initial begin
    cyc(3);
    chk("rst_meter", int'(meter_data), 0);
    chk("rst_state", int'(state), 2);
    chk("rst_expired", int'(expired), 1);
    chk("rst_blank", int'(blank), 0);
    reset = 1'b0;

    rst_205 = 1'b1; cyc(1); clr();
    chk("l205_meter", int'(meter_data), 205);
    chk("l205_state", int'(state), 0);
    chk("l205_blank", int'(blank), 0);
    cyc(48);
    chk("t6_meter", int'(meter_data), 199);
    chk("t6_state", int'(state), 1);
    chk("t6_blank", int'(blank), 0);
    cyc(8);
    chk("t7_meter", int'(meter_data), 198);
    chk("t7_blank", int'(blank), 1);

    rst_10 = 1'b1; cyc(1); clr();
    chk("l10_meter", int'(meter_data), 10);
    chk("l10_state", int'(state), 1);
    cyc(80);
    chk("exp_meter", int'(meter_data), 0);
    chk("exp_flag", int'(expired), 1);
    chk("exp_state", int'(state), 2);
    chk("exp_blank0", int'(blank), 0);
    cyc(4);
    chk("exp_blank1", int'(blank), 1);
    cyc(4);
    chk("exp_blank2", int'(blank), 0);
    chk("exp_hold", int'(meter_data), 0);

    add_150 = 1'b1; cyc(1); clr();
    chk("a150_meter", int'(meter_data), 150);
    chk("a150_state", int'(state), 1);
    chk("a150_blank", int'(blank), 0);
    chk("a150_exp", int'(expired), 0);

    rst_10 = 1'b1; cyc(1); clr();
    add_500 = 1'b1; add_50 = 1'b1; cyc(1); clr();
    chk("prio_meter", int'(meter_data), 510);
    add_500 = 1'b1; cyc(25); clr();
    chk("sat_meter", int'(meter_data), 9999);

    rst_205 = 1'b1; cyc(1); clr();
    cyc(847);
    chk("pre_tick", int'(meter_data), 100);
    add_50 = 1'b1; cyc(1); clr();
    chk("add_tick", int'(meter_data), 149);

    rst_205 = 1'b1; cyc(1); clr();
    add_50 = 1'b1; cyc(2); clr();
    chk("m305", int'(meter_data), 305);
    cyc(38);
    chk("m300", int'(meter_data), 300);
    cyc(3);
    reset = 1'b1; cyc(1); reset = 1'b0;
    chk("mid_rst_meter", int'(meter_data), 0);
    chk("mid_rst_state", int'(state), 2);
    chk("mid_rst_blank", int'(blank), 0);

    for (int blk = 0; blk < 8; blk++) begin
      for (int i = 0; i < 500; i++) begin
        clr();
        reset = 1'b0;
        if (blk % 2 == 0) begin
          add_50  = ($urandom_range(0, 19) == 0);
          add_150 = ($urandom_range(0, 19) == 0);
          add_200 = ($urandom_range(0, 19) == 0);
          add_500 = ($urandom_range(0, 29) == 0);
          rst_10  = ($urandom_range(0, 59) == 0);
          rst_205 = ($urandom_range(0, 59) == 0);
          reset   = ($urandom_range(0, 399) == 0);
        end else begin
          rst_10 = ($urandom_range(0, 299) == 0);
          add_50 = ($urandom_range(0, 199) == 0);
        end
        cyc(1);
      end
    end
    clr();
    reset = 1'b0;
    cyc(2);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule

// File: doc/parking_meter_ctrl.md
PARKING_METER_CTRL -- requirements
Module: parking_meter_ctrl

Interface
REQ-001 Parameter CLK_HZ, default 100_000_000, input clock frequency in Hz; must be even and >= 4.
REQ-002 Parameter MAX_TIME, default 9999, saturation ceiling for remaining seconds.
REQ-003 clk  input  1  single system clock; all logic rising-edge.
REQ-004 reset  input  1  synchronous, active-high.
REQ-005 add_50, add_150, add_200, add_500  input  1 each  add-time requests; one-cycle pulses, debounced externally.
REQ-006 rst_10, rst_205  input  1 each  load-time requests; one-cycle pulses, debounced externally.
REQ-007 meter_data  output  16  remaining seconds as unsigned binary, 0..MAX_TIME; feeds the display controller.
REQ-008 blank  output  1  1 = display dark for the current flash phase.
REQ-009 expired  output  1  1 while remaining time is 0.
REQ-010 state  output  2  current FSM state, for debug.

Function
REQ-011 The block SHALL count down meter_data by 1 on each internal one-second tick, i.e. once every CLK_HZ cycles, while meter_data > 0.
REQ-012 The block SHALL generate a half-second tick every CLK_HZ/2 cycles; every second one-second-aligned half tick is also a second tick.
REQ-013 Only one request SHALL be honoured per cycle, in priority order rst_205 > rst_10 > add_500 > add_200 > add_150 > add_50; lower-priority requests in the same cycle are dropped.
REQ-014 rst_10 / rst_205 SHALL load 10 / 205 and restart both prescalers from count 0.
REQ-015 An add request SHALL set next = min(current - dec + amount, MAX_TIME), where dec = 1 if a second tick occurs in the same cycle and current > 0, else 0; the prescalers are not restarted.
REQ-016 All arithmetic SHALL be performed at 17 bits to avoid overflow before saturation.
REQ-017 meter_data, blank, expired and state SHALL be registered and SHALL reflect a tick or request one cycle after the triggering edge.
REQ-018 The FSM SHALL have three states: HIGH (meter_data >= 200), LOW (1..199) and EXPIRED (0).
REQ-019 The FSM state SHALL be a function of next meter_data, so state always agrees with meter_data.
REQ-020 In HIGH, blank SHALL be 0.
REQ-021 In LOW, blank SHALL toggle on each second tick (2 s period, 50 % duty), starting at 0 on entry to LOW.
REQ-022 In EXPIRED, blank SHALL toggle on each half-second tick (1 s period), starting at 0 on entry to EXPIRED.
REQ-023 In EXPIRED, meter_data SHALL hold 0 and second ticks SHALL not decrement it.
REQ-024 expired SHALL be 1 exactly when state is EXPIRED.
REQ-025 Any request that leaves meter_data > 0 SHALL leave EXPIRED in the same update.

Reset
REQ-026 While reset is high, the block SHALL force meter_data = 0, state = EXPIRED, expired = 1, blank = 0 and both prescalers = 0; all requests are ignored.
REQ-027 Reset asserted mid-countdown SHALL take effect at the next clk edge.
REQ-028 After reset deasserts, the first half-second tick SHALL occur CLK_HZ/2 cycles later.

Structure
REQ-029 Package parking_meter_pkg SHALL hold:
- add amounts 50/150/200/500;
- load values 10/205;
- LOW_THRESH = 200;
- the 2-bit state encoding HIGH / LOW / EXPIRED.
REQ-030 One sub-module, meter_tick_gen, SHALL hold the prescaler: outputs sec_tick and half_tick, with a sync restart input.
REQ-031 The datapath, FSM and blank logic SHALL live in parking_meter_ctrl.

Verification (CLK_HZ = 8: half tick every 4 cycles, second tick every 8)
REQ-032 Reset, then rst_205 pulse: meter_data = 205, state HIGH, blank = 0. After 6 second ticks: meter_data = 199, state LOW, blank = 0. At the next second tick: blank = 1.
REQ-033 meter_data = 9900, add_500: meter_data = 9999 (saturated). Simultaneous add_50 and add_500: only 500 is applied.
REQ-034 rst_10 then 10 second ticks: meter_data = 0, expired = 1. blank then toggles every 4 cycles. A further second tick leaves meter_data = 0.
REQ-035 add_50 in the same cycle as a second tick with meter_data = 100: meter_data = 149 next cycle.
REQ-036 In EXPIRED, add_150: meter_data = 150, state LOW, blank = 0, expired = 0.
REQ-037 Reset pulse at meter_data = 300 mid-count: next cycle meter_data = 0, state EXPIRED, blank = 0.
